// File: rtl/alu_pkg.sv
// Shared ALU control encodings and sequencer state encoding.
// Used by the ALU control decoder, alu_comb and seq_alu.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle combinational ALU operations; iterative shifts live in seq_alu.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  always_comb begin
    y = '0;
    case (alu_ctrl)
      ALU_ADD:   y = a + b;
      ALU_SUB:   y = a - b;
      ALU_AND:   y = a & b;
      ALU_OR:    y = a | b;
      ALU_XOR:   y = a ^ b;
      // Shift codes only reach here with a zero shift amount.
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:   y = a;
      ALU_SLT:   y[0] = ($signed(a) < $signed(b));
      ALU_SLTU:  y[0] = (a < b);
      ALU_PASSB: y = b;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops complete in one cycle, shifts iterate
// one bit per cycle; result/zero are registered and held until the next done.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic [1:0]      state;
  logic [3:0]      op_q;
  logic [4:0]      cnt;
  logic [XLEN-1:0] work;
  logic [XLEN-1:0] shift_nxt;
  logic [XLEN-1:0] comb_y;

  alu_comb #(.XLEN(XLEN)) u_alu_comb (
    .alu_ctrl (alu_ctrl),
    .a        (a),
    .b        (b),
    .y        (comb_y)
  );

  always_comb begin
    shift_nxt = work;
    case (op_q)
      ALU_SLL: shift_nxt = work << 1;
      ALU_SRL: shift_nxt = work >> 1;
      ALU_SRA: shift_nxt = {work[XLEN-1], work[XLEN-1:1]};
      default: shift_nxt = work;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      cnt    <= '0;
      work   <= '0;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q <= alu_ctrl;
            if (is_shift(alu_ctrl) && (b[4:0] != 5'd0)) begin
              state <= ST_SHIFT;
              cnt   <= b[4:0];
              work  <= a;
            end else begin
              result <= comb_y;
              zero   <= (comb_y == '0);
              state  <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          work <= shift_nxt;
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            result <= shift_nxt;
            zero   <= (shift_nxt == '0);
            state  <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu: vector table plus hand-written
// sequences for reset, mid-shift abort and back-to-back issue.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  alu_ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;

  int n_asserts = 0;
  int n_fails   = 0;

  seq_alu #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .alu_ctrl (alu_ctrl),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op; scramble operands and pulse start while it is in flight.
  task automatic run_op(input string name, input logic [3:0] ctrl, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] exp_r, input int exp_lat);
    int cyc;
    int busy_cyc;
    @(negedge clk);
    start = 1'b1; alu_ctrl = ctrl; a = va; b = vb;
    @(negedge clk);
    cyc = 1;
    busy_cyc = busy ? 1 : 0;
    alu_ctrl = ALU_ADD; a = ~va; b = ~vb;
    while (!done && cyc < 64) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy) busy_cyc++;
    end
    check({name, " latency"}, cyc, exp_lat);
    check({name, " busy cycles"}, busy_cyc, exp_lat);
    check({name, " result"}, result, exp_r);
    check({name, " zero"}, {31'd0, zero}, {31'd0, exp_r == 32'd0});
    @(negedge clk);
    start = 1'b0;
    check({name, " done one cycle"}, {31'd0, done}, 32'd0);
    check({name, " idle after done"}, {31'd0, busy}, 32'd0);
    check({name, " result held"}, result, exp_r);
  endtask

  initial begin
    int ndone;
    bit saw_done;

    vecs[0]  = '{ALU_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
    vecs[1]  = '{ALU_SUB,   32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1};
    vecs[2]  = '{ALU_SUB,   32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1};
    vecs[3]  = '{ALU_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1};
    vecs[4]  = '{ALU_OR,    32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1};
    vecs[5]  = '{ALU_XOR,   32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1};
    vecs[6]  = '{ALU_SLL,   32'h00000001, 32'h00000000, 32'h00000001, 1};
    vecs[7]  = '{ALU_SLL,   32'h00000001, 32'h0000001F, 32'h80000000, 32};
    vecs[8]  = '{ALU_SRL,   32'h80000000, 32'h00000003, 32'h10000000, 4};
    vecs[9]  = '{ALU_SRA,   32'h80000000, 32'h00000004, 32'hF8000000, 5};
    vecs[10] = '{ALU_SRA,   32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF, 5};
    vecs[11] = '{ALU_SLL,   32'h00000003, 32'h00000022, 32'h0000000C, 3};
    vecs[12] = '{ALU_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1};
    vecs[13] = '{ALU_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
    vecs[14] = '{ALU_SLT,   32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[15] = '{ALU_SLTU,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1};
    vecs[16] = '{ALU_PASSB, 32'h00000123, 32'hDEADBEEF, 32'hDEADBEEF, 1};
    vecs[17] = '{4'b1111,   32'h00000005, 32'h00000007, 32'h00000000, 1};
    vecs[18] = '{4'b1011,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[19] = '{ALU_SRA,   32'h80000000, 32'h00000000, 32'h80000000, 1};

    rst = 1'b1; start = 1'b1; alu_ctrl = ALU_PASSB; a = '0; b = 32'h1234;
    repeat (2) @(negedge clk);
    check("reset busy",   {31'd0, busy}, 32'd0);
    check("reset done",   {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset zero",   {31'd0, zero}, 32'd1);
    rst = 1'b0; start = 1'b0;

    for (int i = 0; i < 20; i++)
      run_op($sformatf("v%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat);

    // Reset during cycle 3 of an SLL by 10 aborts it without a done pulse.
    run_op("pre-reset passb", ALU_PASSB, 32'h0, 32'h00C0FFEE, 32'h00C0FFEE, 1);
    @(negedge clk);
    start = 1'b1; alu_ctrl = ALU_SLL; a = 32'h1; b = 32'd10;
    saw_done = 1'b0;
    @(negedge clk); start = 1'b0;
    if (done) saw_done = 1'b1;
    @(negedge clk);
    if (done) saw_done = 1'b1;
    @(negedge clk);
    if (done) saw_done = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy",   {31'd0, busy}, 32'd0);
    check("abort result", result, 32'd0);
    check("abort zero",   {31'd0, zero}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort no done", {31'd0, saw_done}, 32'd0);
    run_op("post-reset add", ALU_ADD, 32'd40, 32'd2, 32'd42, 1);

    // Start held high: a latency-1 op is accepted every second cycle.
    @(negedge clk);
    ndone = 0;
    start = 1'b1; alu_ctrl = ALU_ADD; b = 32'd20;
    for (int c = 0; c < 8; c++) begin
      a = c;
      @(negedge clk);
      check($sformatf("b2b done c%0d", c + 1), {31'd0, done}, {31'd0, (c % 2) == 0});
      if (done) begin
        ndone++;
        check($sformatf("b2b result c%0d", c + 1), result, c + 20);
      end
    end
    start = 1'b0;
    check("b2b done count", ndone, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
